// File: rtl/mul_sequencer.sv
// Operand FIFO feeding a handshaked shift-add multiplier; results are captured
// and held for the consumer, with a wait-state timeout that raises a sticky err.
module mul_sequencer #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [1:0] in_tag,
    output logic       mul_start,
    output logic [3:0] mul_multiplicand,
    output logic [3:0] mul_multiplier,
    input  logic       mul_ready,
    input  logic [7:0] mul_product,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_product,
    output logic [1:0] out_tag,
    output logic [7:0] done_cnt,
    output logic       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] tag;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        OUT
    } state_t;

    state_t        state;
    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [WW-1:0] wcnt;
    logic          wait_expired;
    logic [3:0]    hold_a;
    logic [3:0]    hold_b;
    logic [1:0]    hold_tag;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // Pop sees only the registered count, so a fresh push waits a cycle.
    assign pop      = (state == IDLE) && !empty && mul_ready;
    assign head     = mem[rd_ptr];

    assign wait_expired     = (wcnt == WW'(TIMEOUT - 1));
    assign mul_multiplicand = hold_a;
    assign mul_multiplier   = hold_b;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b, tag: in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            mul_start   <= 1'b0;
            hold_a      <= '0;
            hold_b      <= '0;
            hold_tag    <= '0;
            wcnt        <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            out_tag     <= '0;
            done_cnt    <= '0;
            err         <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold_a    <= head.a;
                        hold_b    <= head.b;
                        hold_tag  <= head.tag;
                        mul_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    wcnt <= wcnt + 1'b1;
                    if (!mul_ready) begin
                        state <= WAIT_DONE;
                    end else if (wait_expired) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    wcnt <= wcnt + 1'b1;
                    if (mul_ready) begin
                        out_product <= mul_product;
                        out_tag     <= hold_tag;
                        out_valid   <= 1'b1;
                        state       <= OUT;
                    end else if (wait_expired) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done_cnt  <= done_cnt + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural multiplier that stays
// busy for five cycles after start (load plus four iterations).
module tb_mul_sequencer;

    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_tag;
    logic       mul_start;
    logic [3:0] mul_multiplicand;
    logic [3:0] mul_multiplier;
    logic       mul_ready;
    logic [7:0] mul_product;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_product;
    logic [1:0] out_tag;
    logic [7:0] done_cnt;
    logic       err;

    int n_vec  = 0;
    int n_miss = 0;

    mul_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_ready(mul_ready),
        .mul_product(mul_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag),
        .done_cnt(done_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // stuck: ignore start and stay ready; hold: force not-ready
    logic [2:0] mcnt  = '0;
    logic [7:0] mprod = '0;
    logic       stuck = 1'b0;
    logic       hold  = 1'b0;

    always @(posedge clk) begin
        if (mul_start && !stuck) begin
            mcnt  <= 3'd5;
            mprod <= mul_multiplicand * mul_multiplier;
        end else if (mcnt != 3'd0) begin
            mcnt <= mcnt - 3'd1;
        end
    end
    assign mul_ready   = (mcnt == 3'd0) && !hold;
    assign mul_product = mprod;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] t);
        int n = 0;
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        chk("out_timeout", 32'(out_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_seen;
        int st_seen;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_mul_start", 32'(mul_start), 0);
        chk("rst_done_cnt", 32'(done_cnt), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_out_product", 32'(out_product), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_mcand", 32'(mul_multiplicand), 0);
        rst = 1'b1;
        step();

        // single op latency: 15x15 tag 2
        in_a = 4'd15; in_b = 4'd15; in_tag = 2'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_start_e0", 32'(mul_start), 0);
        step();
        chk("lat_start_e1", 32'(mul_start), 1);
        chk("lat_mcand", 32'(mul_multiplicand), 15);
        chk("lat_mplier", 32'(mul_multiplier), 15);
        step();
        chk("lat_start_e2", 32'(mul_start), 0);
        repeat (5) step();
        chk("lat_ov_e7", 32'(out_valid), 0);
        step();
        chk("lat_ov_e8", 32'(out_valid), 1);
        chk("lat_prod", 32'(out_product), 32'h00E1);
        chk("lat_tag", 32'(out_tag), 2);
        step();
        chk("lat_ov_clr", 32'(out_valid), 0);
        chk("lat_done", 32'(done_cnt), 1);

        // backpressure: fill FIFO while the multiplier is not ready
        hold = 1'b1; out_ready = 1'b0;
        in_a = 4'd3; in_b = 4'd5; in_tag = 2'd1; in_valid = 1'b1;
        step();
        chk("bp_ready_1", 32'(in_ready), 1);
        in_a = 4'd7; in_b = 4'd9; in_tag = 2'd3;
        step();
        chk("bp_full", 32'(in_ready), 0);
        in_a = 4'd2; in_b = 4'd2; in_tag = 2'd0;
        step();
        chk("bp_refused", 32'(in_ready), 0);
        in_valid = 1'b0; hold = 1'b0;
        wait_out(40);
        chk("bp_prod1", 32'(out_product), 32'h0F);
        chk("bp_tag1", 32'(out_tag), 1);
        in_a = 4'd2; in_b = 4'd2; in_tag = 2'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_full_in_out", 32'(in_ready), 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_ov", 32'(out_valid), 1);
            chk("hold_prod", 32'(out_product), 32'h0F);
            chk("hold_tag", 32'(out_tag), 1);
            chk("hold_start", 32'(mul_start), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_hs_ov", 32'(out_valid), 0);
        chk("bp_hs_done", 32'(done_cnt), 2);
        wait_out(40);
        chk("bp_prod2", 32'(out_product), 32'h3F);
        chk("bp_tag2", 32'(out_tag), 3);
        step();
        chk("bp_done3", 32'(done_cnt), 3);
        wait_out(40);
        chk("bp_prod3", 32'(out_product), 32'h04);
        chk("bp_tag3", 32'(out_tag), 0);
        step();
        chk("bp_done4", 32'(done_cnt), 4);

        // timeout: multiplier never drops ready
        stuck = 1'b1;
        in_a = 4'd5; in_b = 4'd5; in_tag = 2'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("to_start", 32'(mul_start), 1);
        step();
        repeat (TIMEOUT - 1) step();
        chk("to_err_early", 32'(err), 0);
        chk("to_ov_early", 32'(out_valid), 0);
        step();
        chk("to_err", 32'(err), 1);
        chk("to_ov", 32'(out_valid), 0);
        chk("to_done", 32'(done_cnt), 4);
        stuck = 1'b0;
        push(4'd4, 4'd3, 2'd2);
        wait_out(40);
        chk("to_next_prod", 32'(out_product), 32'h0C);
        chk("to_next_tag", 32'(out_tag), 2);
        chk("to_err_sticky", 32'(err), 1);
        step();
        chk("to_next_done", 32'(done_cnt), 5);

        // reset during WAIT_DONE with one entry queued
        push(4'd6, 4'd7, 2'd1);
        push(4'd2, 4'd3, 2'd0);
        step(); step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mr_ov", 32'(out_valid), 0);
        chk("mr_in_ready", 32'(in_ready), 1);
        chk("mr_done", 32'(done_cnt), 0);
        chk("mr_err", 32'(err), 0);
        ov_seen = 0; st_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) ov_seen++;
            if (mul_start) st_seen++;
        end
        chk("mr_no_output", 32'(ov_seen), 0);
        chk("mr_no_start", 32'(st_seen), 0);

        // done_cnt wrap over 256 operations
        for (int i = 0; i < 256; i++) begin
            push(4'd1, 4'd1, 2'(i));
            wait_out(40);
            step();
            if (i == 254) chk("wrap_255", 32'(done_cnt), 255);
        end
        chk("wrap_0", 32'(done_cnt), 0);
        chk("wrap_prod", 32'(out_product), 1);
        chk("wrap_tag", 32'(out_tag), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
